// File: rtl/elbeth_writeback_unit_if.sv
// elbeth_writeback_unit_if
// Bundles the execute-side request, the data-memory response, the decode
// bypass/hazard signals and the register-file write port of the writeback unit.
//   master : the writeback unit (drives ex_ready, rd_*, ctrl_w_enable, fwd_*,
//            load_hazard, load_timeout)
//   slave  : the surrounding pipeline (execute, memory, decode, register file)
interface elbeth_writeback_unit_if #(
  parameter int unsigned XLEN = 32
);
  // execute stage request
  logic            ex_valid;
  logic            ex_ready;
  logic [4:0]      ex_rd_addr;
  logic [XLEN-1:0] ex_rd_data;
  logic            ex_is_load;
  logic [2:0]      ex_load_funct3;
  logic [1:0]      ex_load_offset;
  // data-memory response
  logic            mem_rsp_valid;
  logic [XLEN-1:0] mem_rsp_data;
  // decode source addresses
  logic [4:0]      id_rs1_addr;
  logic [4:0]      id_rs2_addr;
  // register-file write port
  logic [4:0]      rd_addr;
  logic [XLEN-1:0] rd_data;
  logic            ctrl_w_enable;
  // bypass / hazard / status
  logic            fwd_rs1_hit;
  logic            fwd_rs2_hit;
  logic [XLEN-1:0] fwd_data;
  logic            load_hazard;
  logic            load_timeout;

  modport master (
    input  ex_valid, ex_rd_addr, ex_rd_data, ex_is_load, ex_load_funct3,
           ex_load_offset, mem_rsp_valid, mem_rsp_data, id_rs1_addr, id_rs2_addr,
    output ex_ready, rd_addr, rd_data, ctrl_w_enable, fwd_rs1_hit, fwd_rs2_hit,
           fwd_data, load_hazard, load_timeout
  );

  modport slave (
    output ex_valid, ex_rd_addr, ex_rd_data, ex_is_load, ex_load_funct3,
           ex_load_offset, mem_rsp_valid, mem_rsp_data, id_rs1_addr, id_rs2_addr,
    input  ex_ready, rd_addr, rd_data, ctrl_w_enable, fwd_rs1_hit, fwd_rs2_hit,
           fwd_data, load_hazard, load_timeout
  );
endinterface

// File: rtl/elbeth_writeback_unit.sv
// elbeth_writeback_unit
// Write-side master of the elbeth register file. ALU results are written one
// cycle after acceptance; loads wait in WAIT_LOAD for a memory response, whose
// word is byte/halfword extracted and sign/zero extended before the write. A
// load with no response within LOAD_TIMEOUT wait cycles is abandoned with a
// one-cycle load_timeout pulse. Decode gets a same-cycle bypass of the current
// write and a hazard flag while a load is pending.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : elbeth_writeback_unit_if.master (request, response, decode, write port)
module elbeth_writeback_unit #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned LOAD_TIMEOUT = 16,
  parameter int unsigned CNT_W        = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  elbeth_writeback_unit_if.master bus
);

  typedef enum logic [0:0] {
    S_IDLE      = 1'b0,
    S_WAIT_LOAD = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOAD_TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]      cap_rd_q, cap_rd_d;
  logic [2:0]      cap_f3_q, cap_f3_d;
  logic [1:0]      cap_off_q, cap_off_d;
  logic [4:0]      rd_addr_q, rd_addr_d;
  logic [XLEN-1:0] rd_data_q, rd_data_d;
  logic            wen_q, wen_d;
  logic            tmo_q, tmo_d;

  logic            accept;
  logic [7:0]      byte_v;
  logic [15:0]     half_v;
  logic [XLEN-1:0] load_result;

  assign bus.ex_ready = (state_q == S_IDLE);
  assign accept       = bus.ex_valid & bus.ex_ready;

  // Load data extraction and extension from the captured funct3/offset.
  always_comb begin
    unique case (cap_off_q)
      2'd0:    byte_v = bus.mem_rsp_data[7:0];
      2'd1:    byte_v = bus.mem_rsp_data[15:8];
      2'd2:    byte_v = bus.mem_rsp_data[23:16];
      default: byte_v = bus.mem_rsp_data[31:24];
    endcase
    half_v = cap_off_q[1] ? bus.mem_rsp_data[31:16] : bus.mem_rsp_data[15:0];
    unique case (cap_f3_q)
      3'b000:  load_result = {{(XLEN-8){byte_v[7]}}, byte_v};
      3'b100:  load_result = {{(XLEN-8){1'b0}}, byte_v};
      3'b001:  load_result = {{(XLEN-16){half_v[15]}}, half_v};
      3'b101:  load_result = {{(XLEN-16){1'b0}}, half_v};
      default: load_result = bus.mem_rsp_data;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cap_rd_d  = cap_rd_q;
    cap_f3_d  = cap_f3_q;
    cap_off_d = cap_off_q;
    rd_addr_d = rd_addr_q;
    rd_data_d = rd_data_q;
    wen_d     = 1'b0;
    tmo_d     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (bus.ex_is_load) begin
            cap_rd_d  = bus.ex_rd_addr;
            cap_f3_d  = bus.ex_load_funct3;
            cap_off_d = bus.ex_load_offset;
            cnt_d     = '0;
            state_d   = S_WAIT_LOAD;
          end else begin
            rd_addr_d = bus.ex_rd_addr;
            rd_data_d = bus.ex_rd_data;
            wen_d     = (bus.ex_rd_addr != 5'd0);
          end
        end
      end
      S_WAIT_LOAD: begin
        // A response on the last wait cycle takes priority over the timeout.
        if (bus.mem_rsp_valid) begin
          rd_addr_d = cap_rd_q;
          rd_data_d = load_result;
          wen_d     = (cap_rd_q != 5'd0);
          state_d   = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          tmo_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      cap_rd_q  <= '0;
      cap_f3_q  <= '0;
      cap_off_q <= '0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
      wen_q     <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cap_rd_q  <= cap_rd_d;
      cap_f3_q  <= cap_f3_d;
      cap_off_q <= cap_off_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
      wen_q     <= wen_d;
      tmo_q     <= tmo_d;
    end
  end

  assign bus.rd_addr       = rd_addr_q;
  assign bus.rd_data       = rd_data_q;
  assign bus.ctrl_w_enable = wen_q;
  assign bus.load_timeout  = tmo_q;
  assign bus.fwd_data      = rd_data_q;
  assign bus.fwd_rs1_hit   = wen_q & (rd_addr_q == bus.id_rs1_addr) & (bus.id_rs1_addr != 5'd0);
  assign bus.fwd_rs2_hit   = wen_q & (rd_addr_q == bus.id_rs2_addr) & (bus.id_rs2_addr != 5'd0);
  assign bus.load_hazard   = (state_q == S_WAIT_LOAD) & (cap_rd_q != 5'd0) &
                             ((cap_rd_q == bus.id_rs1_addr) | (cap_rd_q == bus.id_rs2_addr));

endmodule

// File: tb/tb_elbeth_writeback_unit.sv
module tb_elbeth_writeback_unit;

  logic clk;
  logic rst_n;
  int unsigned n_pass;
  int unsigned n_total;

  elbeth_writeback_unit_if #(.XLEN(32)) bus ();

  elbeth_writeback_unit #(
    .XLEN(32),
    .LOAD_TIMEOUT(16),
    .CNT_W(5)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got running expected finished");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Reference extraction: pick the addressed byte/halfword by shifting, then
  // extend by adding the high-bit fill when the value is negative.
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] w);
    int unsigned o, b, h;
    o = off;
    b = (w >> (8 * o)) & 32'd255;
    h = (w >> (16 * (o / 2))) & 32'd65535;
    case (f3)
      3'd0:    return (b >= 128) ? (b + 32'hFFFF_FF00) : b;
      3'd4:    return b;
      3'd1:    return (h >= 32768) ? (h + 32'hFFFF_0000) : h;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  task automatic do_alu(input logic [4:0] rd, input logic [31:0] data,
                        input logic [4:0] rs1, input logic [4:0] rs2, input string tag);
    bus.ex_valid   = 1'b1;
    bus.ex_is_load = 1'b0;
    bus.ex_rd_addr = rd;
    bus.ex_rd_data = data;
    #1;
    chk({tag, "_ready"}, bus.ex_ready, 1'b1);
    step();
    bus.ex_valid    = 1'b0;
    bus.id_rs1_addr = rs1;
    bus.id_rs2_addr = rs2;
    #1;
    chk({tag, "_wen"}, bus.ctrl_w_enable, rd != 5'd0);
    chk({tag, "_addr"}, bus.rd_addr, rd);
    chk({tag, "_data"}, bus.rd_data, data);
    chk({tag, "_tmo"}, bus.load_timeout, 1'b0);
    chk({tag, "_fwd1"}, bus.fwd_rs1_hit, (rd != 0) && (rs1 == rd) && (rs1 != 0));
    chk({tag, "_fwd2"}, bus.fwd_rs2_hit, (rd != 0) && (rs2 == rd) && (rs2 != 0));
    chk({tag, "_fwdd"}, bus.fwd_data, data);
    chk({tag, "_hz"}, bus.load_hazard, 1'b0);
  endtask

  // delay = index of the wait cycle carrying the response; >= 16 means none.
  task automatic do_load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off,
                         input logic [31:0] word, input logic [31:0] exp,
                         input int unsigned delay, input logic [4:0] rs1,
                         input logic [4:0] rs2, input string tag);
    bus.ex_valid       = 1'b1;
    bus.ex_is_load     = 1'b1;
    bus.ex_rd_addr     = rd;
    bus.ex_rd_data     = $urandom;
    bus.ex_load_funct3 = f3;
    bus.ex_load_offset = off;
    #1;
    chk({tag, "_ready"}, bus.ex_ready, 1'b1);
    step();
    bus.ex_valid    = 1'b0;
    bus.ex_is_load  = 1'b0;
    bus.id_rs1_addr = rs1;
    bus.id_rs2_addr = rs2;
    for (int unsigned i = 0; i < 16; i++) begin
      bus.mem_rsp_data = (i == delay) ? word : $urandom;
      bus.mem_rsp_valid = (i == delay);
      #1;
      chk({tag, "_hz"}, bus.load_hazard, (rd != 0) && ((rd == rs1) || (rd == rs2)));
      chk({tag, "_busy"}, bus.ex_ready, 1'b0);
      chk({tag, "_nowen"}, bus.ctrl_w_enable, 1'b0);
      chk({tag, "_notmo"}, bus.load_timeout, 1'b0);
      step();
      bus.mem_rsp_valid = 1'b0;
      if (i == delay) begin
        chk({tag, "_wen"}, bus.ctrl_w_enable, rd != 5'd0);
        chk({tag, "_addr"}, bus.rd_addr, rd);
        chk({tag, "_data"}, bus.rd_data, exp);
        chk({tag, "_tmo0"}, bus.load_timeout, 1'b0);
        chk({tag, "_idle"}, bus.ex_ready, 1'b1);
        return;
      end
    end
    chk({tag, "_tmo"}, bus.load_timeout, 1'b1);
    chk({tag, "_tmownen"}, bus.ctrl_w_enable, 1'b0);
    chk({tag, "_tmoidle"}, bus.ex_ready, 1'b1);
    step();
    chk({tag, "_tmopulse"}, bus.load_timeout, 1'b0);
  endtask

  initial begin
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [31:0] w;
    n_pass = 0;
    n_total = 0;
    rst_n = 1'b0;
    bus.ex_valid = 1'b0;
    bus.ex_is_load = 1'b0;
    bus.ex_rd_addr = '0;
    bus.ex_rd_data = '0;
    bus.ex_load_funct3 = '0;
    bus.ex_load_offset = '0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data = '0;
    bus.id_rs1_addr = '0;
    bus.id_rs2_addr = '0;
    step();
    step();
    chk("rst_addr", bus.rd_addr, 5'd0);
    chk("rst_data", bus.rd_data, 32'd0);
    chk("rst_wen", bus.ctrl_w_enable, 1'b0);
    chk("rst_tmo", bus.load_timeout, 1'b0);
    chk("rst_ready", bus.ex_ready, 1'b1);
    chk("rst_hz", bus.load_hazard, 1'b0);
    rst_n = 1'b1;
    step();

    // Reset in the middle of a load, then a stray response.
    bus.ex_valid = 1'b1; bus.ex_is_load = 1'b1; bus.ex_rd_addr = 5'd7;
    bus.ex_load_funct3 = 3'b010; bus.ex_load_offset = 2'd0;
    step();
    bus.ex_valid = 1'b0; bus.ex_is_load = 1'b0;
    step();
    chk("midrst_busy", bus.ex_ready, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", bus.ex_ready, 1'b1);
    step();
    rst_n = 1'b1;
    step();
    bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'hDEAD_BEEF;
    step();
    bus.mem_rsp_valid = 1'b0;
    chk("midrst_wen", bus.ctrl_w_enable, 1'b0);
    chk("midrst_addr", bus.rd_addr, 5'd0);
    chk("midrst_data", bus.rd_data, 32'd0);
    chk("midrst_tmo", bus.load_timeout, 1'b0);
    chk("midrst_ready2", bus.ex_ready, 1'b1);

    // Back-to-back ALU writes, then the same to x0.
    for (int unsigned k = 0; k < 2; k++) begin
      logic [4:0] ra, rb;
      ra = (k == 0) ? 5'd3 : 5'd0;
      rb = (k == 0) ? 5'd4 : 5'd0;
      bus.ex_valid = 1'b1; bus.ex_is_load = 1'b0;
      bus.ex_rd_addr = ra; bus.ex_rd_data = 32'h11;
      step();
      chk("b2b_wen1", bus.ctrl_w_enable, k == 0);
      chk("b2b_addr1", bus.rd_addr, ra);
      chk("b2b_data1", bus.rd_data, 32'h11);
      bus.ex_rd_addr = rb; bus.ex_rd_data = 32'h22;
      step();
      bus.ex_valid = 1'b0;
      chk("b2b_wen2", bus.ctrl_w_enable, k == 0);
      chk("b2b_addr2", bus.rd_addr, rb);
      chk("b2b_data2", bus.rd_data, 32'h22);
      step();
      chk("b2b_wen3", bus.ctrl_w_enable, 1'b0);
    end

    // Load extension table on word 0x80FF7F01.
    do_load(5'd1, 3'b000, 2'd3, 32'h80FF_7F01, 32'hFFFF_FF80, 0, 5'd0, 5'd0, "lb");
    do_load(5'd2, 3'b100, 2'd2, 32'h80FF_7F01, 32'h0000_00FF, 1, 5'd0, 5'd0, "lbu");
    do_load(5'd3, 3'b001, 2'd2, 32'h80FF_7F01, 32'hFFFF_80FF, 2, 5'd0, 5'd0, "lh");
    do_load(5'd4, 3'b101, 2'd0, 32'h80FF_7F01, 32'h0000_7F01, 3, 5'd0, 5'd0, "lhu");
    do_load(5'd6, 3'b010, 2'd1, 32'h80FF_7F01, 32'h80FF_7F01, 4, 5'd0, 5'd0, "lw");

    // Forwarding and hazard.
    do_alu(5'd5, 32'h1234_5678, 5'd0, 5'd5, "fwd5");
    do_load(5'd9, 3'b010, 2'd0, 32'hCAFE_0001, 32'hCAFE_0001, 5, 5'd9, 5'd3, "hz9");

    // Timeout and response on the final wait cycle.
    do_load(5'd12, 3'b010, 2'd0, 32'h0BAD_F00D, 32'h0BAD_F00D, 99, 5'd0, 5'd0, "tmo");
    do_load(5'd13, 3'b010, 2'd0, 32'h600D_F00D, 32'h600D_F00D, 15, 5'd0, 5'd0, "last");

    // ALU request held while a load is pending.
    bus.ex_valid = 1'b1; bus.ex_is_load = 1'b1; bus.ex_rd_addr = 5'd10;
    bus.ex_load_funct3 = 3'b010; bus.ex_load_offset = 2'd0;
    step();
    bus.ex_is_load = 1'b0; bus.ex_rd_addr = 5'd11; bus.ex_rd_data = 32'hAA;
    step();
    chk("hold_busy", bus.ex_ready, 1'b0);
    chk("hold_nowen", bus.ctrl_w_enable, 1'b0);
    bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'h5555_0000;
    step();
    bus.mem_rsp_valid = 1'b0;
    chk("hold_ldaddr", bus.rd_addr, 5'd10);
    chk("hold_lddata", bus.rd_data, 32'h5555_0000);
    chk("hold_ready", bus.ex_ready, 1'b1);
    step();
    bus.ex_valid = 1'b0;
    chk("hold_aluwen", bus.ctrl_w_enable, 1'b1);
    chk("hold_aluaddr", bus.rd_addr, 5'd11);
    chk("hold_aludata", bus.rd_data, 32'hAA);
    step();
    chk("hold_wenoff", bus.ctrl_w_enable, 1'b0);

    // Randomized mix checked against the reference model.
    for (int unsigned t = 0; t < 60; t++) begin
      rd  = 5'($urandom);
      rs1 = ($urandom_range(0, 1) == 1) ? rd : 5'($urandom);
      rs2 = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        do_alu(rd, $urandom, rs1, rs2, "rnd_alu");
      end else begin
        f3  = 3'($urandom);
        off = 2'($urandom);
        w   = $urandom;
        do_load(rd, f3, off, w, ref_load(f3, off, w), $urandom_range(0, 18), rs1, rs2, "rnd_ld");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/elbeth_writeback_unit.md
Name: elbeth_writeback_unit

Overview:
Write-side master of the elbeth general-purpose register file. Accepts completed results from the execute stage, waits for load data from the data-memory response channel, and extracts and extends that data. It drives the register-file write port (rd_addr, rd_data, ctrl_w_enable). It also gives decode a same-cycle bypass for the write in flight and a hazard flag for a pending load.

Parameters:
XLEN, 32, data width of results and register-file write data
LOAD_TIMEOUT, 16, cycles to wait for mem_rsp_valid before abandoning a load (min 2)
CNT_W, 5, width of timeout counter; must hold LOAD_TIMEOUT-1

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
ex_valid  input  1  execute stage presents a result/load request
ex_ready  output  1  unit can accept; high only in IDLE (combinational from state)
ex_rd_addr  input  5  destination register
ex_rd_data  input  XLEN  ALU result (ignored for loads)
ex_is_load  input  1  request is a load; data arrives on mem_rsp_*
ex_load_funct3  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
ex_load_offset  input  2  byte address bits [1:0] of load
mem_rsp_valid  input  1  load data valid (single-cycle pulse)
mem_rsp_data  input  XLEN  aligned 32-bit memory word
id_rs1_addr  input  5  decode read address a
id_rs2_addr  input  5  decode read address b
rd_addr  output  5  register-file write address
rd_data  output  XLEN  register-file write data
ctrl_w_enable  output  1  register-file write strobe
fwd_rs1_hit  output  1  rs1 matches current write
fwd_rs2_hit  output  1  rs2 matches current write
fwd_data  output  XLEN  equals rd_data, for bypass mux
load_hazard  output  1  a decode source matches the pending load destination
load_timeout  output  1  one-cycle pulse: load abandoned

Behaviour:
- Reset (async, rst_n=0): state=IDLE, rd_addr=0, rd_data=0, ctrl_w_enable=0, load_timeout=0, counter=0, captured load fields=0. A load in flight is discarded. A mem_rsp_valid arriving after reset release is ignored.
- States: IDLE, WAIT_LOAD.
- Accept = ex_valid & ex_ready.
- IDLE, accept, ex_is_load=0: next edge registers rd_addr=ex_rd_addr, rd_data=ex_rd_data and ctrl_w_enable=(ex_rd_addr!=0). Latency 1. Stay IDLE; back-to-back accepts give back-to-back writes.
- IDLE, accept, ex_is_load=1: capture rd_addr, funct3, offset. Counter=0, go to WAIT_LOAD. ctrl_w_enable=0 next cycle.
- IDLE, no accept: ctrl_w_enable=0 next cycle. A mem_rsp_valid in IDLE is ignored.
- WAIT_LOAD, mem_rsp_valid=1: extract and extend per funct3.
  - LB/LBU use byte [8*offset+7 : 8*offset]. LB sign-extends; LBU zero-extends.
  - LH/LHU use halfword offset[1]; offset[0] is ignored. LH sign-extends; LHU zero-extends.
  - LW, and any other funct3, pass the full word.
  - Next edge: rd_data=result, rd_addr=captured, ctrl_w_enable=(captured rd!=0), state IDLE.
- WAIT_LOAD, no rsp: counter++. If counter==LOAD_TIMEOUT-1 and no rsp, the next edge sets load_timeout=1 for one cycle, state IDLE, no write. A rsp in that same cycle wins: the write happens and no timeout fires.
- Writes to x0 are never strobed; rd_addr/rd_data still update.
- Forwarding, combinational:
  - fwd_rsN_hit = ctrl_w_enable & (rd_addr==id_rsN_addr) & (id_rsN_addr!=0).
  - fwd_data = rd_data.
- load_hazard = (state==WAIT_LOAD) & (captured rd!=0) & (captured rd==id_rs1_addr | captured rd==id_rs2_addr).
- ctrl_w_enable is high for exactly one cycle per committed write.

Test Plan:
- Reset mid-load: accept LW rd=7, assert rst_n=0 before rsp, release, then pulse rsp -> no write, state IDLE, ex_ready=1, all outputs 0.
- ALU back-to-back: accept rd=3 data=0x11 then rd=4 data=0x22 on consecutive cycles -> ctrl_w_enable high two consecutive cycles with (3,0x11),(4,0x22). Same stimulus with rd=0 -> ctrl_w_enable=0.
- Load extension: mem word 0x80FF7F01.
  - LB off=3 -> 0xFFFFFF80.
  - LBU off=2 -> 0x000000FF.
  - LH off=2 -> 0xFFFF80FF.
  - LHU off=0 -> 0x00007F01.
  - LW -> 0x80FF7F01.
  - Each is written 1 cycle after rsp; ex_ready=0 from accept until the rsp edge.
- Forward/hazard: write rd=5 active with id_rs2_addr=5 -> fwd_rs2_hit=1, fwd_data=rd_data. Pending load rd=9 with id_rs1_addr=9 -> load_hazard=1. id_rs1_addr=0 -> no hit.
- Timeout: LOAD_TIMEOUT=16, no rsp -> load_timeout pulses one cycle 16 cycles after the accept edge, no write, ex_ready=1 after. Rsp on the final wait cycle -> write occurs, no pulse.
- ALU accept while in WAIT_LOAD: ex_valid held -> not accepted until after the load write, then written 1 cycle after acceptance.
